// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad code-entry block: digit width, key encoding
// and the press/release tracking state machine states.
package keypad_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;
  localparam logic       KEY_NONE_N = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } key_state_t;

  // Codes above 9 from the encoder are not digits and count as no key.
  function automatic logic key_valid(input logic vn, input logic [DIGIT_W-1:0] d);
    return !vn && (d <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/keypad_code_entry_if.sv
// Link to the 10-key priority encoder: encoded digit, active-low valid,
// and the active-low enable that masks the encoder.
interface keypad_code_entry_if;
  import keypad_pkg::*;

  logic [DIGIT_W-1:0] key_d;
  logic               key_vn;
  logic               enc_enablen;

  modport master (output key_d, output key_vn, input  enc_enablen);
  modport slave  (input  key_d, input  key_vn, output enc_enablen);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_code_entry.sv
// Debounces encoded keypad presses and shifts one BCD digit per press into an
// N-digit buffer; masks the encoder once the buffer is full.
module keypad_code_entry
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  keypad_code_entry_if.slave                enc,
  input  logic                              clear,
  output logic [DIGIT_W*NUM_DIGITS-1:0]     digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
  output logic                              full,
  output logic                              key_strobe,
  output logic                              overrun
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int COUNT_W = $clog2(NUM_DIGITS + 1);
  localparam int BUF_W   = DIGIT_W * NUM_DIGITS;

  logic [DIGIT_W:0]   sync_in, sync_out;
  logic               vn_s;
  logic [DIGIT_W-1:0] d_s;
  logic               key_ok;

  assign sync_in = {enc.key_vn, enc.key_d};

  sync_2ff #(
    .WIDTH     (DIGIT_W + 1),
    .RESET_VAL ({KEY_NONE_N, {DIGIT_W{1'b0}}})
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sync_in),
    .q   (sync_out)
  );

  assign {vn_s, d_s} = sync_out;
  assign key_ok      = key_valid(vn_s, d_s);

  key_state_t         state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [DIGIT_W-1:0] cand, cand_next;
  logic               accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      cand  <= cand_next;
    end
  end

  // Press needs DEBOUNCE_CYCLES identical valid samples; release needs as many idle ones.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_ok) begin
          cand_next  = d_s;
          cnt_next   = CNT_W'(1);
          state_next = PRESS;
        end
      end
      PRESS: begin
        if (!key_ok || (d_s != cand)) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          accept     = 1'b1;
          state_next = HELD;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        if (vn_s) begin
          cnt_next   = CNT_W'(1);
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!vn_s) begin
          state_next = HELD;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [BUF_W+DIGIT_W-1:0] shifted;
  logic [BUF_W-1:0]         digits_next;
  logic [COUNT_W-1:0]       count_next;
  logic                     strobe_next, overrun_next;

  assign shifted = {digits, cand};
  assign full    = (count == COUNT_W'(NUM_DIGITS));

  // Clear wins over a same-cycle accept, so that digit is silently dropped.
  always_comb begin
    digits_next  = digits;
    count_next   = count;
    strobe_next  = 1'b0;
    overrun_next = overrun;
    if (clear) begin
      digits_next  = '0;
      count_next   = '0;
      overrun_next = 1'b0;
    end else if (accept) begin
      if (!full) begin
        digits_next = shifted[BUF_W-1:0];
        count_next  = count + 1'b1;
        strobe_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  // The mask is registered from the next count so it tracks full without lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits          <= '0;
      count           <= '0;
      key_strobe      <= 1'b0;
      overrun         <= 1'b0;
      enc.enc_enablen <= 1'b0;
    end else begin
      digits          <= digits_next;
      count           <= count_next;
      key_strobe      <= strobe_next;
      overrun         <= overrun_next;
      enc.enc_enablen <= (count_next == COUNT_W'(NUM_DIGITS));
    end
  end

endmodule
